rv_multicycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle RV32I core.
- Sequences each instruction through fetch, decode, execute, memory and writeback, one datapath step per state.
- Drives the datapath ALU (alu_e), immediate generator (imm_e), branch comparator (branch_e), mux selects, write strobes and the shared instruction/data memory request handshake.
- Keeps a retired-instruction counter.

---
 rtl/rv_multicycle_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rv_multicycle_ctrl
// Brief    : Main control FSM of the multi-cycle RV32I core (one datapath step per state).
// Revision : 1.0 - initial release
// ============================================================================

package rv_multicycle_ctrl_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI
    } alu_e;
    typedef enum logic [2:0] {
        IMM_I_TYPE, IMM_STORE, IMM_BRANCH, IMM_U_TYPE, IMM_JAL
    } imm_e;
    typedef enum logic [1:0] {BR_EQ, BR_NE, BR_LT, BR_GE} branch_e;
endpackage

module rv_multicycle_ctrl
    import rv_multicycle_ctrl_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr,
    input  logic                 mem_ready,
    input  logic                 br_taken,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 mem_addr_sel,
    output logic                 ir_we,
    output logic                 alu_out_we,
    output alu_e                 alu_op,
    output logic                 alu_a_sel,
    output logic                 alu_b_sel,
    output imm_e                 imm_sel,
    output branch_e              br_cond,
    output logic                 br_unsigned,
    output logic                 rf_we,
    output logic [1:0]           wb_sel,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM_ADDR, S_MEM_RD,
        S_MEM_WR, S_WB, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    state_t      state;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        decode_bad;
    logic        retire;
    imm_e        imm_by_op;
    alu_e        alu_by_f3;
    logic        unused_fields;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign funct7        = instr[31:25];
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    assign retire = (state == S_WB) || (state == S_BRANCH) || (state == S_JUMP) ||
                    ((state == S_MEM_WR) && mem_ready);

    always_comb begin
        decode_bad = 1'b0;
        case (opcode)
            OPC_OP:
                decode_bad = !((funct7 == 7'b0000000) ||
                               ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            OPC_OP_IMM: begin
                // Only the shift forms constrain imm[11:5]
                if (funct3 == 3'b001)
                    decode_bad = (funct7 != 7'b0000000);
                else if (funct3 == 3'b101)
                    decode_bad = !((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
            end
            OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR:
                decode_bad = 1'b0;
            OPC_BRANCH:
                decode_bad = (funct3[2:1] == 2'b01);
            default:
                decode_bad = 1'b1;
        endcase
    end

    always_comb begin
        imm_by_op = IMM_I_TYPE;
        case (opcode)
            OPC_STORE:            imm_by_op = IMM_STORE;
            OPC_BRANCH:           imm_by_op = IMM_BRANCH;
            OPC_LUI, OPC_AUIPC:   imm_by_op = IMM_U_TYPE;
            OPC_JAL:              imm_by_op = IMM_JAL;
            default:              imm_by_op = IMM_I_TYPE;
        endcase
    end

    always_comb begin
        alu_by_f3 = ALU_ADD;
        case (funct3)
            3'b000:  alu_by_f3 = ((opcode == OPC_OP) && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_by_f3 = ALU_SLL;
            3'b010:  alu_by_f3 = ALU_SLT;
            3'b011:  alu_by_f3 = ALU_SLTU;
            3'b100:  alu_by_f3 = ALU_XOR;
            3'b101:  alu_by_f3 = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  alu_by_f3 = ALU_OR;
            default: alu_by_f3 = ALU_AND;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            instret <= '0;
            illegal <= 1'b0;
        end else begin
            if (retire)
                instret <= instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
            case (state)
                S_FETCH:
                    if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    if (decode_bad) begin
                        state   <= S_TRAP;
                        illegal <= 1'b1;
                    end else begin
                        case (opcode)
                            OPC_LOAD, OPC_STORE: state <= S_MEM_ADDR;
                            OPC_BRANCH:          state <= S_BRANCH;
                            OPC_JAL, OPC_JALR:   state <= S_JUMP;
                            default:             state <= S_EXEC;
                        endcase
                    end
                end
                S_EXEC:     state <= S_WB;
                S_MEM_ADDR: state <= (opcode == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:
                    if (mem_ready) state <= S_WB;
                S_MEM_WR:
                    if (mem_ready) state <= S_FETCH;
                S_WB, S_BRANCH, S_JUMP:
                    state <= S_FETCH;
                S_TRAP:     state <= S_TRAP;
                default:    state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        alu_out_we   = 1'b0;
        alu_op       = ALU_ADD;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 1'b0;
        imm_sel      = IMM_I_TYPE;
        br_cond      = BR_EQ;
        br_unsigned  = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = 2'd0;
        pc_we        = 1'b0;
        pc_sel       = 2'd0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            S_DECODE:
                imm_sel = imm_by_op;
            S_EXEC: begin
                alu_out_we = 1'b1;
                imm_sel    = imm_by_op;
                case (opcode)
                    OPC_LUI: begin
                        alu_op    = ALU_LUI;
                        alu_b_sel = 1'b1;
                    end
                    OPC_AUIPC: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                    end
                    default: begin
                        alu_op    = alu_by_f3;
                        alu_b_sel = (opcode == OPC_OP_IMM);
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_out_we = 1'b1;
                alu_b_sel  = 1'b1;
                imm_sel    = (opcode == OPC_STORE) ? IMM_STORE : IMM_I_TYPE;
            end
            S_MEM_RD: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
            end
            S_MEM_WR: begin
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr_sel = 1'b1;
                pc_we        = mem_ready;
            end
            S_WB: begin
                rf_we  = 1'b1;
                pc_we  = 1'b1;
                wb_sel = (opcode == OPC_LOAD) ? 2'd1 : 2'd0;
            end
            S_BRANCH: begin
                imm_sel     = IMM_BRANCH;
                br_cond     = funct3[2] ? (funct3[0] ? BR_GE : BR_LT) : (funct3[0] ? BR_NE : BR_EQ);
                br_unsigned = funct3[1];
                pc_we       = 1'b1;
                pc_sel      = br_taken ? 2'd1 : 2'd0;
            end
            S_JUMP: begin
                rf_we  = 1'b1;
                wb_sel = 2'd2;
                pc_we  = 1'b1;
                if (opcode == OPC_JAL) begin
                    imm_sel = IMM_JAL;
                    pc_sel  = 2'd1;
                end else begin
                    alu_b_sel = 1'b1;
                    pc_sel    = 2'd2;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_rv_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_multicycle_ctrl
// Brief    : Self-checking bench; per-instruction cycle expectations built from the ISA rules.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rv_multicycle_ctrl;
    import rv_multicycle_ctrl_pkg::*;

    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   instr = '0;
    logic          mem_ready = 1'b0;
    logic          br_taken = 1'b0;
    logic          mem_req, mem_we, mem_addr_sel, ir_we, alu_out_we;
    alu_e          alu_op;
    logic          alu_a_sel, alu_b_sel;
    imm_e          imm_sel;
    branch_e       br_cond;
    logic          br_unsigned, rf_we;
    logic [1:0]    wb_sel;
    logic          pc_we;
    logic [1:0]    pc_sel;
    logic          illegal;
    logic [IW-1:0] instret;

    rv_multicycle_ctrl #(.INSTRET_W(IW)) dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .br_taken(br_taken),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
        .alu_out_we(alu_out_we), .alu_op(alu_op), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .imm_sel(imm_sel), .br_cond(br_cond), .br_unsigned(br_unsigned), .rf_we(rf_we),
        .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel), .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, mem_we, mem_addr_sel, ir_we, alu_out_we;
        logic [3:0] alu_op;
        logic       alu_a_sel, alu_b_sel;
        logic [2:0] imm_sel;
        logic [1:0] br_cond;
        logic       br_unsigned, rf_we;
        logic [1:0] wb_sel;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic [31:0] instr;
        logic        ready;
        logic        taken;
        logic        retire;
        outs_t       o;
    } step_t;

    step_t q[$];
    int    ncmp = 0;
    int    nfail = 0;
    int    cnt = 0;

    function automatic outs_t idle();
        outs_t o = '0;
        o.alu_op  = ALU_ADD;
        o.imm_sel = IMM_I_TYPE;
        o.br_cond = BR_EQ;
        return o;
    endfunction

    function automatic logic [2:0] imm_for(logic [6:0] op);
        case (op)
            7'b0100011:             return IMM_STORE;
            7'b1100011:             return IMM_BRANCH;
            7'b0110111, 7'b0010111: return IMM_U_TYPE;
            7'b1101111:             return IMM_JAL;
            default:                return IMM_I_TYPE;
        endcase
    endfunction

    function automatic bit legal(logic [31:0] i);
        logic [6:0] op = i[6:0];
        logic [2:0] f3 = i[14:12];
        logic [6:0] f7 = i[31:25];
        case (op)
            7'b0110011: return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
            7'b0010011: return (f3 == 1) ? (f7 == 7'h00) :
                               (f3 == 5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            7'b1100011: return !(f3 == 2 || f3 == 3);
            7'b0110111, 7'b0010111, 7'b0000011, 7'b0100011, 7'b1101111, 7'b1100111: return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] alu_for(logic [31:0] i);
        alu_e tbl [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        int   f3 = int'(i[14:12]);
        if (f3 == 0 && i[6:0] == 7'b0110011 && i[30]) return ALU_SUB;
        if (f3 == 5 && i[30]) return ALU_SRA;
        return tbl[f3];
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [9] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011,
                                 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111};
        logic [31:0] i = $urandom;
        i[6:0] = ops[$urandom_range(0, 8)];
        if (i[6:0] == 7'b0110011)
            i[31:25] = ($urandom_range(0, 1) == 1 && (i[14:12] == 0 || i[14:12] == 5)) ? 7'h20 : 7'h00;
        if (i[6:0] == 7'b0010011 && i[14:12] == 1) i[31:25] = 7'h00;
        if (i[6:0] == 7'b0010011 && i[14:12] == 5) i[31:25] = $urandom_range(0, 1) == 1 ? 7'h20 : 7'h00;
        if (i[6:0] == 7'b1100011 && (i[14:12] == 2 || i[14:12] == 3)) i[14] = 1'b1;
        return i;
    endfunction

    task automatic push(input logic [31:0] ins, input logic rdy, input logic tk, input logic ret, input outs_t o);
        step_t s;
        s.instr = ins; s.ready = rdy; s.taken = tk; s.retire = ret; s.o = o;
        q.push_back(s);
    endtask

    // Expected cycle-by-cycle behaviour of one instruction, from fetch to retirement (or trap).
    task automatic build(input logic [31:0] ins, input int fwait, input int mwait, input logic tk);
        outs_t      o;
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        for (int k = 0; k < fwait; k++) begin
            o = idle(); o.mem_req = 1;
            push($urandom, 1'b0, 1'($urandom), 1'b0, o);
        end
        o = idle(); o.mem_req = 1; o.ir_we = 1;
        push($urandom, 1'b1, 1'($urandom), 1'b0, o);
        o = idle(); o.imm_sel = imm_for(op);
        push(ins, 1'($urandom), 1'($urandom), 1'b0, o);
        if (!legal(ins)) begin
            for (int k = 0; k < 5; k++) begin
                o = idle(); o.illegal = 1;
                push(ins, 1'($urandom), 1'($urandom), 1'b0, o);
            end
            return;
        end
        case (op)
            7'b0000011, 7'b0100011: begin
                o = idle(); o.alu_out_we = 1; o.alu_b_sel = 1; o.imm_sel = imm_for(op);
                push(ins, 1'($urandom), 1'($urandom), 1'b0, o);
                for (int k = 0; k <= mwait; k++) begin
                    o = idle(); o.mem_req = 1; o.mem_addr_sel = 1;
                    o.mem_we = (op == 7'b0100011);
                    o.pc_we  = (op == 7'b0100011) && (k == mwait);
                    push(ins, k == mwait, 1'($urandom), (op == 7'b0100011) && (k == mwait), o);
                end
                if (op == 7'b0000011) begin
                    o = idle(); o.rf_we = 1; o.pc_we = 1; o.wb_sel = 1;
                    push(ins, 1'($urandom), 1'($urandom), 1'b1, o);
                end
            end
            7'b1100011: begin
                o = idle(); o.imm_sel = IMM_BRANCH; o.pc_we = 1; o.pc_sel = tk ? 2'd1 : 2'd0;
                o.br_cond = f3[2] ? (f3[0] ? BR_GE : BR_LT) : (f3[0] ? BR_NE : BR_EQ);
                o.br_unsigned = f3[1];
                push(ins, 1'($urandom), tk, 1'b1, o);
            end
            7'b1101111, 7'b1100111: begin
                o = idle(); o.rf_we = 1; o.wb_sel = 2; o.pc_we = 1;
                if (op == 7'b1101111) begin
                    o.imm_sel = IMM_JAL; o.pc_sel = 1;
                end else begin
                    o.alu_b_sel = 1; o.pc_sel = 2;
                end
                push(ins, 1'($urandom), 1'($urandom), 1'b1, o);
            end
            default: begin
                o = idle(); o.alu_out_we = 1; o.imm_sel = imm_for(op);
                if (op == 7'b0110111) begin
                    o.alu_op = ALU_LUI; o.alu_b_sel = 1;
                end else if (op == 7'b0010111) begin
                    o.alu_a_sel = 1; o.alu_b_sel = 1;
                end else begin
                    o.alu_op = alu_for(ins); o.alu_b_sel = (op == 7'b0010011);
                end
                push(ins, 1'($urandom), 1'($urandom), 1'b0, o);
                o = idle(); o.rf_we = 1; o.pc_we = 1;
                push(ins, 1'($urandom), 1'($urandom), 1'b1, o);
            end
        endcase
    endtask

    // Called and returns on a falling edge; each step drives, samples, then crosses one rising edge.
    task automatic run_seq(input int limit);
        step_t s;
        outs_t act;
        int    n = 0;
        while (q.size() > 0 && n < limit) begin
            s = q.pop_front();
            instr = s.instr; mem_ready = s.ready; br_taken = s.taken;
            #1;
            act = {mem_req, mem_we, mem_addr_sel, ir_we, alu_out_we, alu_op, alu_a_sel, alu_b_sel,
                   imm_sel, br_cond, br_unsigned, rf_we, wb_sel, pc_we, pc_sel, illegal};
            ncmp++;
            assert (act === s.o) else begin
                nfail++;
                $error("FAIL outs instr=%h observed=%h expected=%h", s.instr, act, s.o);
            end
            ncmp++;
            assert (instret === cnt[IW-1:0]) else begin
                nfail++;
                $error("FAIL instret observed=%0d expected=%0d", instret, cnt[IW-1:0]);
            end
            @(negedge clk);
            if (s.retire) cnt = (cnt + 1) % (1 << IW);
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_ready = 1'b0; instr = $urandom;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
    endtask

    task automatic one(input logic [31:0] ins, input int fwait, input int mwait, input logic tk);
        build(ins, fwait, mwait, tk);
        run_seq(1000);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        // Directed scenarios
        one(32'h00500093, 0, 0, 1'b0);          // ADDI x1,x0,5
        ncmp++;
        assert (instret === 4'd1) else begin
            nfail++; $error("FAIL addi_retire observed=%0d expected=1", instret);
        end
        one(32'h40208133, 1, 0, 1'b0);          // SUB
        one(32'h4010D093, 0, 0, 1'b0);          // SRAI
        one(32'h0000A103, 0, 3, 1'b0);          // LW, 3 wait cycles
        one(32'h0020A023, 2, 1, 1'b0);          // SW
        one(32'h0020E463, 0, 0, 1'b1);          // BLTU taken
        one(32'h0020E463, 0, 0, 1'b0);          // BLTU not taken
        one(32'h000080E7, 0, 0, 1'b0);          // JALR
        one(32'h000000EF, 0, 0, 1'b0);          // JAL
        one(32'h123450B7, 0, 0, 1'b0);          // LUI
        one(32'h00001097, 0, 0, 1'b0);          // AUIPC

        // Reset while a load waits on memory
        build(32'h0000A103, 0, 3, 1'b0);
        run_seq(5);
        q.delete();
        do_reset();
        one(32'h00500093, 0, 0, 1'b0);

        // Counter wrap: 16 retirements on a 4-bit counter returns to zero
        do_reset();
        for (int k = 0; k < 16; k++) one(32'h00500093, 0, 0, 1'b0);
        ncmp++;
        assert (instret === 4'd0) else begin
            nfail++; $error("FAIL instret_wrap observed=%0d expected=0", instret);
        end

        // Randomized legal instruction stream
        for (int k = 0; k < 200; k++)
            one(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));

        // Illegal encodings trap and stay trapped until reset
        one(32'h0000000F, 0, 0, 1'b0);          // FENCE
        do_reset();
        one(32'h00002063, 0, 0, 1'b0);          // branch funct3 010
        do_reset();
        one(32'h02208133, 0, 0, 1'b0);          // OP funct7 0000001
        do_reset();
        one(32'h40209133, 0, 0, 1'b0);          // OP funct7 0100000 with funct3 001
        do_reset();
        one(32'h40109093, 0, 0, 1'b0);          // SLLI imm[11:5]=0100000
        do_reset();
        one(32'h00500093, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
